fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width of each requester port and of the FIFO write port.
REQ-002 SHALL have parameter BURST, default 4, legal 1..16, meaning maximum words written per grant.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  meaning requester i has a word on dat_i and asks to write it.
REQ-006 SHALL have ports dat0, dat1, dat2, dat3  input  WIDTH each  meaning the write data of requesters 0..3.
REQ-007 SHALL have port ack  output  4  meaning the word of requester i is written into the FIFO this cycle.
REQ-008 SHALL have port fifo_wr_en  output  1  meaning the write enable to the shared Fifo.
REQ-009 SHALL have port fifo_wr_dat  output  WIDTH  meaning the write data to the shared Fifo.
REQ-010 SHALL have port fifo_full  input  1  meaning Fifo full.
REQ-011 SHALL have port fifo_afull  input  1  meaning Fifo almost full.
REQ-012 SHALL have port gnt_vld  output  1  meaning a requester currently holds the grant (state GRANT).
REQ-013 SHALL have port gnt_id  output  2  meaning the index of the requester holding or last holding the grant.

Function
REQ-014 SHALL implement two states, IDLE and GRANT, plus a 2-bit round-robin pointer (last) and a burst counter cnt of ceil(log2(BURST+1)) bits.
REQ-015 SHALL, in IDLE with req != 0 and the start condition (REQ-029/030) true, select the first set req bit searching upward from last+1 mod 4, load gnt_id with it, clear cnt, and enter GRANT on the next edge.
REQ-016 SHALL stay in IDLE with no register change when req == 0 or the start condition is false.
REQ-017 SHALL drive fifo_wr_en = gnt_vld & req[gnt_id] & !fifo_full combinationally, with no added latency.
REQ-018 SHALL drive fifo_wr_dat = dat[gnt_id] whenever gnt_vld is 1, and all zeros otherwise.
REQ-019 SHALL drive ack[gnt_id] = fifo_wr_en and every other ack bit 0, so that at most one ack bit is 1 in any cycle.
REQ-020 SHALL increment cnt on each cycle in which fifo_wr_en is 1.
REQ-021 SHALL leave GRANT for IDLE on the next edge, setting last = gnt_id, when req[gnt_id] is 0 or when a write occurs with cnt == BURST-1.
REQ-022 SHALL, in GRANT with fifo_full 1 and req[gnt_id] 1, stall: no write, cnt held, grant kept indefinitely.
REQ-023 SHALL insert exactly one IDLE cycle between consecutive grants; the minimum per-grant overhead is 1 cycle.
REQ-024 SHALL ignore req bits other than req[gnt_id] while in GRANT.
REQ-025 SHALL, with req == 4'b1111 held and Fifo never full, grant in the order 0,1,2,3,0,... with BURST writes each.

Reset
REQ-026 SHALL, while rst is 1, force state IDLE, last = 3 (so requester 0 has first priority), cnt = 0, gnt_id = 0.
REQ-027 SHALL, during reset, drive gnt_vld = 0, fifo_wr_en = 0, ack = 0, fifo_wr_dat = 0.
REQ-028 SHALL, on reset asserted mid-GRANT, abandon the burst immediately; no write occurs in any cycle where rst is 1.

Configuration
REQ-029 SHALL, when macro FIFO_WR_ARB_AFULL_EN is defined, use start condition !fifo_afull, so no new grant is issued while fifo_afull is 1; a grant already held is unaffected by fifo_afull.
REQ-030 SHALL, when FIFO_WR_ARB_AFULL_EN is not defined, use start condition !fifo_full and ignore fifo_afull entirely.

Verification
REQ-031 SHALL cover: reset, req=4'b0001 with dat0 incrementing from 1, BURST=4 -> gnt_vld rises 1 cycle later, words 1,2,3,4 written on 4 consecutive cycles, 1 IDLE cycle, next grant to requester 0 again.
REQ-032 SHALL cover: req=4'b1111 held, BURST=4, Fifo DEPTH 16 drained constantly -> gnt_id sequence 0,1,2,3, each with 4 acks, ack one-hot or zero every cycle.
REQ-033 SHALL cover: grant to requester 2, fifo_full forced 1 for 3 cycles after the 2nd word -> fifo_wr_en 0 for those 3 cycles, cnt holds at 2, remaining 2 words are written after release.
REQ-034 SHALL cover: req[1] dropped after 1 word with BURST=4 -> return to IDLE next cycle, last=1, pending req[3] granted next.
REQ-035 SHALL cover: with FIFO_WR_ARB_AFULL_EN defined, Fifo DEPTH 4 ALMOST 1 holding 3 entries, req=4'b0001 -> no grant until a read lowers the count to 2; without the macro the grant is issued, 1 word is written, and the grant then stalls on full.
REQ-036 SHALL cover: rst pulsed for 1 cycle mid-burst -> fifo_wr_en 0 immediately, gnt_vld 0, next grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Four-requester round-robin write arbiter feeding one shared FIFO, up to BURST words per grant.
// Optional macro FIFO_WR_ARB_AFULL_EN: new grants wait for !fifo_afull instead of !fifo_full.
module fifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] dat0,
  input  logic [WIDTH-1:0] dat1,
  input  logic [WIDTH-1:0] dat2,
  input  logic [WIDTH-1:0] dat3,
  output logic [3:0]       ack,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_dat,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  output logic             gnt_vld,
  output logic [1:0]       gnt_id
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_gnt_id;
  logic [CW-1:0]    r_cnt;

  logic [0:0]       w_state_nxt;
  logic [1:0]       w_last_nxt;
  logic [1:0]       w_gnt_id_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_start;
  logic             w_grant;
  logic             w_req_cur;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_dat_sel;

  // First set request bit found searching upward from last+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last_v;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_v + 2'(k);
      if (!found && req_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef FIFO_WR_ARB_AFULL_EN
  assign w_start = !fifo_afull;
`else
  // fifo_afull has no effect in this build; the AND with zero only marks it as consumed.
  assign w_start = !fifo_full | (fifo_afull & 1'b0);
`endif

  assign w_grant   = (r_state == ST_GRANT);
  assign w_req_cur = req[r_gnt_id];
  assign w_wr_en   = w_grant & w_req_cur & !fifo_full & !rst;

  always_comb begin
    w_dat_sel = '0;
    case (r_gnt_id)
      2'd0:    w_dat_sel = dat0;
      2'd1:    w_dat_sel = dat1;
      2'd2:    w_dat_sel = dat2;
      2'd3:    w_dat_sel = dat3;
      default: w_dat_sel = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_gnt_id_nxt = r_gnt_id;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if ((req != 4'b0000) && w_start) begin
          w_gnt_id_nxt = rr_pick(req, r_last);
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!w_req_cur) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gnt_id;
        end else if (w_wr_en) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_gnt_id;
          end else begin
            w_state_nxt = ST_GRANT;
          end
        end else begin
          // Full FIFO with the owner still requesting: hold everything.
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 2'd3;
      r_gnt_id <= 2'd0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign gnt_vld     = w_grant;
  assign gnt_id      = r_gnt_id;
  assign fifo_wr_en  = w_wr_en;
  assign fifo_wr_dat = w_grant ? w_dat_sel : '0;
  assign ack         = w_wr_en ? (4'b0001 << r_gnt_id) : 4'b0000;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: requesters hold fixed word queues, a transaction-level
// round-robin model predicts the write stream, and a negedge monitor checks every write.
module tb_fifo_wr_arb;
  localparam int W = 8;
  localparam int B = 4;
  localparam int BUDGET = 2000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] dat0 = '0, dat1 = '0, dat2 = '0, dat3 = '0;
  logic [3:0]   ack;
  logic         fifo_wr_en;
  logic [W-1:0] fifo_wr_dat;
  logic         fifo_full = 1'b0;
  logic         fifo_afull = 1'b0;
  logic         gnt_vld;
  logic [1:0]   gnt_id;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] d;
  } exp_t;

  logic [W-1:0] wq[4][$];
  exp_t         expq[$];
  exp_t         mon_e;
  int           m_last = 3;
  int           checks = 0;
  int           failures = 0;
  logic         afull_lvl;

  fifo_wr_arb #(.WIDTH(W), .BURST(B)) dut (
    .clk(clk), .rst(rst), .req(req),
    .dat0(dat0), .dat1(dat1), .dat2(dat2), .dat3(dat3),
    .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_wr_dat(fifo_wr_dat),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: reset quiescence, interface rules, and scoreboard pops on every write.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_gnt_vld", gnt_vld, 0);
      chk("rst_ack", ack, 0);
      chk("rst_wr_dat", fifo_wr_dat, 0);
    end else begin
      chk("wr_en_rule", fifo_wr_en, gnt_vld & req[gnt_id] & ~fifo_full);
      if (!gnt_vld) chk("dat_idle", fifo_wr_dat, 0);
      if (fifo_wr_en) begin
        chk("ack_onehot", ack, 4'b0001 << gnt_id);
        if (expq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          chk("wr_id", gnt_id, mon_e.id);
          chk("wr_dat", fifo_wr_dat, mon_e.d);
        end
      end else begin
        chk("ack_zero", ack, 0);
      end
    end
  end

  task automatic drive_inputs();
    req  = {wq[3].size() > 0, wq[2].size() > 0, wq[1].size() > 0, wq[0].size() > 0};
    dat0 = (wq[0].size() > 0) ? wq[0][0] : '0;
    dat1 = (wq[1].size() > 0) ? wq[1][0] : '0;
    dat2 = (wq[2].size() > 0) ? wq[2][0] : '0;
    dat3 = (wq[3].size() > 0) ? wq[3][0] : '0;
  endtask

  // Round-robin over fixed queues; returns cycles needed when the FIFO never fills.
  task automatic build_model(output int exp_cyc);
    int  rem[4];
    int  pos[4];
    int  grants = 0, words = 0, shorts = 0, id, n, c;
    bit  last_short = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = wq[i].size();
      pos[i] = 0;
    end
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      id = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (id < 0 && rem[c] > 0) id = c;
      end
      n = (rem[id] < B) ? rem[id] : B;
      for (int j = 0; j < n; j++) expq.push_back('{id: 2'(id), d: wq[id][pos[id] + j]});
      pos[id] += n;
      rem[id] -= n;
      grants++;
      words += n;
      last_short = (n < B);
      if (last_short) shorts++;
      m_last = id;
    end
    // A burst cut short by a dropped request costs one extra cycle, except the final one.
    if (last_short) shorts--;
    exp_cyc = words + grants + shorts;
  endtask

  task automatic run(input string name, input int mode, input int st_from, input int st_len,
                     input int rst_at, input int exp_extra);
    int         exp_cyc;
    int         cyc = 0;
    logic [3:0] a;
    build_model(exp_cyc);
    while ((wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size() > 0) && cyc < BUDGET) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) wq[i].delete();
        expq.delete();
        m_last = 3;
        drive_inputs();
        return;
      end
      case (mode)
        0: begin fifo_full = 1'b0; fifo_afull = afull_lvl; end
        1: begin fifo_full = ($urandom_range(0, 3) == 0); fifo_afull = 1'($urandom_range(0, 1)); end
        2: begin fifo_full = (cyc + 1 >= st_from) && (cyc + 1 < st_from + st_len); fifo_afull = 1'b0; end
        default: begin fifo_full = 1'b0; fifo_afull = 1'b0; end
      endcase
      drive_inputs();
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (a[i]) void'(wq[i].pop_front());
      cyc++;
    end
    drive_inputs();
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    chk({name, "_in_budget"}, cyc < BUDGET, 1);
    chk({name, "_drained"}, expq.size(), 0);
    if (mode != 1) chk({name, "_cycles"}, cyc, exp_cyc + exp_extra);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b1111;
    fifo_full = 1'b0;
    fifo_afull = 1'b0;
    @(negedge clk);
    chk("rst_gnt_id", gnt_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = 3;
    drive_inputs();
  endtask

  task automatic idle(input int n);
    drive_inputs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef FIFO_WR_ARB_AFULL_EN
    afull_lvl = 1'b0;
`else
    afull_lvl = 1'b1;
`endif
    do_reset();

    for (int k = 1; k <= 8; k++) wq[0].push_back(W'(k));
    run("single_req", 0, 0, 0, -1, 0);
    idle(3);

    do_reset();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) wq[i].push_back(W'(i * 16 + k));
    run("all_req", 0, 0, 0, -1, 0);
    idle(3);

    do_reset();
    wq[1].push_back(8'h11);
    wq[3].push_back(8'h31);
    wq[3].push_back(8'h32);
    run("drop_req", 0, 0, 0, -1, 0);
    idle(3);

    do_reset();
    for (int k = 1; k <= 6; k++) wq[2].push_back(W'(8'h20 + k));
    run("full_stall", 2, 4, 3, -1, 3);
    idle(3);

    do_reset();
    for (int k = 1; k <= 8; k++) wq[0].push_back(W'(8'h40 + k));
    run("rst_mid", 0, 0, 0, 3, 0);
    wq[2].push_back(8'hA2);
    wq[0].push_back(8'hA0);
    run("after_rst", 0, 0, 0, -1, 0);
    idle(3);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        int n = $urandom_range(0, 9);
        for (int k = 0; k < n; k++) wq[i].push_back(W'($urandom));
      end
      run("random", 1, 0, 0, -1, 0);
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
